// File: rtl/kama_pkg.sv
// Shared fetch-path types: address/instruction words, fetch FSM states and
// the fixed instruction size in bytes.
package kama_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned INST_BYTES = 4;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] inst_t;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: instruction-memory request/response, redirect
// input and the downstream instruction handshake.
//   master : the fetch sequencer (drives imem request and inst outputs)
//   slave  : memory / core environment
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_resp_valid;
    logic [DATA_WIDTH-1:0] imem_resp_data;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst_data;
    logic [ADDR_WIDTH-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_out_reg.sv
// Downstream instruction output register.
//   clk, rst         : clock, async active-low reset
//   load             : capture load_data/load_pc and set valid
//   clear            : drop valid (wins over load); data/pc keep their value
//   valid, data, pc  : registered instruction presented downstream
module fetch_out_reg #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic [ADDR_WIDTH-1:0] load_pc,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] pc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one instruction-memory read at a time,
// presents each returned word downstream with its PC, and restarts the
// stream on redirect, discarding any response belonging to the old stream.
//   clk, rst : clock, async active-low reset
//   bus      : fetch_sequencer_if.master (imem req/resp, redirect, inst out)
module fetch_sequencer
    import kama_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic clk,
    input  logic rst,
    fetch_sequencer_if.master bus
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  kill_q, kill_d;
    logic                  req_valid_q, req_valid_d;
    logic                  out_load, out_clear;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_pc;

    // Next-state, pc/kill update and output-register control
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        out_load  = 1'b0;
        out_clear = 1'b0;

        if (bus.redirect_valid) begin
            // Redirect overrides every other event this cycle
            pc_d      = bus.redirect_pc;
            out_clear = 1'b1;
            case (state_q)
                ST_REQ: begin
                    // Pending request stays on the bus; its response is stale
                    kill_d = 1'b1;
                    if (bus.imem_req_ready) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        kill_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        kill_d = 1'b1;
                    end
                end
                default: begin
                    kill_d  = 1'b0;
                    state_d = ST_REQ;
                end
            endcase
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_REQ;
                ST_REQ: begin
                    if (bus.imem_req_ready) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = ST_REQ;
                        end else begin
                            // Register is now occupied, so wait for consumption
                            out_load = 1'b1;
                            pc_d     = pc_q + ADDR_WIDTH'(INST_BYTES);
                            state_d  = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_valid && bus.inst_ready) begin
                        out_clear = 1'b1;
                        state_d   = ST_REQ;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end

        // Request outputs are registered from the next state; the address is
        // captured only on entry to REQ so it stays stable until accepted.
        req_valid_d = (state_d == ST_REQ);
        addr_d      = ((state_d == ST_REQ) && (state_q != ST_REQ)) ? pc_d : addr_q;
    end

    // State and registered request outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            kill_q      <= 1'b0;
            req_valid_q <= 1'b0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            kill_q      <= kill_d;
            req_valid_q <= req_valid_d;
            addr_q      <= addr_d;
        end
    end

    fetch_out_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (out_load),
        .clear     (out_clear),
        .load_data (bus.imem_resp_data),
        .load_pc   (pc_q),
        .valid     (out_valid),
        .data      (out_data),
        .pc        (out_pc)
    );

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_addr      = addr_q;
    assign bus.inst_valid     = out_valid;
    assign bus.inst_data      = out_data;
    assign bus.inst_pc        = out_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by a
// randomized phase. A memory model answers accepted requests after a chosen
// latency; a stream model tracks which PC must be delivered next.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    fetch_sequencer #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] req_log[$];
    logic [31:0] del_log[$];
    logic        pend;
    logic        resp_auto;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          lat;
    logic [31:0] model_pc;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a ^ 32'hA5A5_5A5A) + {a[15:0], a[31:16]};
    endfunction

    function automatic logic [31:0] req_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] del_at(input int i);
        if (i < del_log.size()) return del_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: bookkeeping on the current inputs, edge, then memory reply
    task automatic step();
        logic        hold_req, hold_inst;
        logic [31:0] h_addr, h_data, h_pc;
        chk("one_outstanding", bus.imem_req_valid && (pend || resp_auto), 1'b0);
        chk("no_req_while_held", bus.imem_req_valid && bus.inst_valid, 1'b0);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            req_log.push_back(bus.imem_addr);
            pend      = 1'b1;
            pend_addr = bus.imem_addr;
            pend_cnt  = lat;
        end
        if (bus.inst_valid && bus.inst_ready && !bus.redirect_valid) begin
            del_log.push_back(bus.inst_pc);
            chk("deliver_pc", bus.inst_pc, model_pc);
            chk("deliver_data", bus.inst_data, mem_f(bus.inst_pc));
            model_pc = model_pc + 32'd4;
        end
        if (bus.redirect_valid) model_pc = bus.redirect_pc;
        hold_req  = bus.imem_req_valid && !bus.imem_req_ready;
        h_addr    = bus.imem_addr;
        hold_inst = bus.inst_valid && !bus.inst_ready && !bus.redirect_valid;
        h_data    = bus.inst_data;
        h_pc      = bus.inst_pc;
        @(posedge clk);
        @(negedge clk);
        if (hold_req) begin
            chk("req_stable_valid", bus.imem_req_valid, 1'b1);
            chk("req_stable_addr", bus.imem_addr, h_addr);
        end
        if (hold_inst) begin
            chk("inst_stable_valid", bus.inst_valid, 1'b1);
            chk("inst_stable_data", bus.inst_data, h_data);
            chk("inst_stable_pc", bus.inst_pc, h_pc);
        end
        bus.redirect_valid  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        resp_auto           = 1'b0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mem_f(pend_addr);
                pend                = 1'b0;
                resp_auto           = 1'b1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Hold reset over two edges, check reset values, release into BOOT
    task automatic do_reset();
        rst                 = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        pend                = 1'b0;
        resp_auto           = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", bus.imem_req_valid, 1'b0);
        chk("rst_inst_valid", bus.inst_valid, 1'b0);
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        chk("rst_inst_data", bus.inst_data, 32'h0);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        req_log.delete();
        del_log.delete();
        model_pc = RST_PC;
        rst      = 1'b1;
    endtask

    task automatic boot();
        chk("boot_no_req", bus.imem_req_valid, 1'b0);
        step();
        chk("boot_req_valid", bus.imem_req_valid, 1'b1);
        chk("boot_req_addr", bus.imem_addr, RST_PC);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d0;
        rst                 = 1'b0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.inst_ready      = 1'b0;
        lat                 = 1;
        pend                = 1'b0;
        resp_auto           = 1'b0;

        // Streaming with ready memory and consumer
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        do_reset();
        boot();
        run(12);
        chk("t034_req0", req_at(0), 32'h100);
        chk("t034_req1", req_at(1), 32'h104);
        chk("t034_req2", req_at(2), 32'h108);
        chk("t034_del0", del_at(0), 32'h100);
        chk("t034_del1", del_at(1), 32'h104);
        chk("t034_del2", del_at(2), 32'h108);

        // Back-pressure from downstream
        bus.inst_ready = 1'b0;
        do_reset();
        boot();
        for (int i = 0; i < 20 && !bus.inst_valid; i++) step();
        chk("t035_got_inst", bus.inst_valid, 1'b1);
        d0 = bus.inst_data;
        chk("t035_data", d0, mem_f(32'h100));
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t035_held_valid", bus.inst_valid, 1'b1);
            chk("t035_held_data", bus.inst_data, d0);
            chk("t035_held_pc", bus.inst_pc, 32'h100);
            chk("t035_no_req", bus.imem_req_valid, 1'b0);
        end
        chk("t035_req_count", 64'(req_log.size()), 64'd1);
        bus.inst_ready = 1'b1;
        step();
        chk("t035_cleared", bus.inst_valid, 1'b0);
        chk("t035_next_req", bus.imem_req_valid, 1'b1);
        chk("t035_next_addr", bus.imem_addr, 32'h104);

        // Redirect while waiting for a response
        lat = 3;
        do_reset();
        boot();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        lat                = 1;
        step();
        run(12);
        chk("t036_req0", req_at(0), 32'h100);
        chk("t036_req1", req_at(1), 32'h200);
        chk("t036_del0", del_at(0), 32'h200);

        // Memory stall with redirect during the pending request
        bus.imem_req_ready = 1'b0;
        do_reset();
        boot();
        step();
        chk("t037_addr_c1", bus.imem_addr, 32'h100);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        step();
        chk("t037_valid_c2", bus.imem_req_valid, 1'b1);
        chk("t037_addr_c2", bus.imem_addr, 32'h100);
        bus.imem_req_ready = 1'b1;
        step();
        run(12);
        chk("t037_req0", req_at(0), 32'h100);
        chk("t037_req1", req_at(1), 32'h300);
        chk("t037_del0", del_at(0), 32'h300);

        // Redirect during BOOT near the top of the address space
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        chk("t038_req_valid", bus.imem_req_valid, 1'b1);
        chk("t038_req_addr", bus.imem_addr, 32'hFFFF_FFFC);
        run(12);
        chk("t038_req1_wrap", req_at(1), 32'h0);
        chk("t038_del0", del_at(0), 32'hFFFF_FFFC);
        chk("t038_del1", del_at(1), 32'h0);

        // Asynchronous reset, then reset during WAIT with stray responses
        bus.imem_req_ready = 1'b0;
        do_reset();
        step();
        rst = 1'b0;
        #1;
        chk("t039_async_req_valid", bus.imem_req_valid, 1'b0);
        chk("t039_async_addr", bus.imem_addr, 32'h0);
        bus.imem_req_ready = 1'b1;
        lat                = 3;
        do_reset();
        step();
        step();
        do_reset();
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hBAD0_BAD0;
        chk("t039_boot_no_req", bus.imem_req_valid, 1'b0);
        bus.imem_req_ready = 1'b0;
        step();
        chk("t039_req_valid", bus.imem_req_valid, 1'b1);
        chk("t039_req_addr", bus.imem_addr, RST_PC);
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = 32'hBAD1_BAD1;
        step();
        chk("t039_no_inst", bus.inst_valid, 1'b0);
        bus.imem_req_ready = 1'b1;
        lat                = 1;
        run(10);
        chk("t039_req0", req_at(0), 32'h100);
        chk("t039_del0", del_at(0), 32'h100);

        // Randomized traffic against the stream model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bus.imem_req_ready = ($urandom_range(0, 9) < 7);
            bus.inst_ready     = ($urandom_range(0, 9) < 6);
            lat                = int'($urandom_range(1, 3));
            if ($urandom_range(0, 99) < 4) begin
                bus.redirect_valid = 1'b1;
                if ($urandom_range(0, 3) == 0)
                    bus.redirect_pc = 32'hFFFF_FFF0 | ($urandom() & 32'hC);
                else
                    bus.redirect_pc = $urandom() & 32'hFFFF_FFFC;
            end
            step();
        end
        chk("rand_progress", 64'(del_log.size() >= 30), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the byte-address width of every PC and memory address.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the instruction word width.
REQ-003 Parameter RESET_PC, default 0, SHALL set the first fetch address after reset.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 imem_req_valid  out  1  SHALL indicate a read request to instruction memory.
REQ-007 imem_req_ready  in  1  SHALL indicate the memory accepts the request this cycle.
REQ-008 imem_addr  out  ADDR_WIDTH  SHALL carry the request byte address.
REQ-009 imem_resp_valid  in  1  SHALL indicate the read data is present, one pulse per accepted request, in order.
REQ-010 imem_resp_data  in  DATA_WIDTH  SHALL carry the read data.
REQ-011 redirect_valid  in  1  SHALL request a fetch-stream restart.
REQ-012 redirect_pc  in  ADDR_WIDTH  SHALL carry the restart address.
REQ-013 inst_valid  out  1  SHALL indicate a fetched instruction is presented downstream.
REQ-014 inst_ready  in  1  SHALL indicate downstream consumes the instruction this cycle.
REQ-015 inst_data, inst_pc  out  DATA_WIDTH, ADDR_WIDTH  SHALL carry the instruction and its address.

Function
REQ-016 States SHALL be BOOT, REQ, WAIT, HOLD; at most one memory request outstanding.
REQ-017 BOOT SHALL last exactly one cycle after reset release, then go to REQ, imem_req_valid low.
REQ-018 REQ: imem_req_valid=1, imem_addr=pc; on imem_req_ready go to WAIT; addr and valid SHALL stay stable until accepted.
REQ-019 WAIT: on imem_resp_valid with kill clear, load inst_data/inst_pc into the output register, set inst_valid, pc<=pc+4 (modulo 2^ADDR_WIDTH).
REQ-020 WAIT exit: if output register free after that cycle (empty or consumed same cycle) go REQ, else go HOLD.
REQ-021 HOLD: inst_valid held with stable data until inst_ready; on handshake go REQ the same cycle.
REQ-022 Memory request issue latency: REQ entered the cycle after the output register frees; no new request while the register holds an unconsumed instruction.
REQ-023 Redirect in any state SHALL set pc<=redirect_pc and clear inst_valid next cycle, regardless of inst_ready.
REQ-024 Redirect while a request is accepted-but-unanswered (WAIT, or REQ with imem_req_ready same cycle) SHALL set kill; that response SHALL be discarded, kill cleared, go REQ at redirect_pc.
REQ-025 Redirect in REQ without acceptance SHALL keep the pending request stable and mark it killed; after its response, re-fetch from redirect_pc.
REQ-026 Redirect coincident with imem_resp_valid SHALL discard that response; redirect wins over any other event.
REQ-027 Redirect in HOLD or BOOT SHALL go to REQ at redirect_pc next cycle.
REQ-028 Back-to-back redirects SHALL take the last redirect_pc.
REQ-029 imem_resp_valid outside WAIT SHALL be ignored.

Reset
REQ-030 While rst low: state=BOOT, pc=RESET_PC, kill=0, imem_req_valid=0, inst_valid=0, imem_addr=0, inst_data=0, inst_pc=0.
REQ-031 Reset asserted mid-request SHALL abandon it; any later response before the first new request SHALL be ignored.

Structure
REQ-032 Shared package kama_pkg SHALL hold addr_t, inst_t, the fetch_state_e enum and INST_BYTES=4.
REQ-033 The output register SHALL be one sub-module, fetch_out_reg (valid/data/pc, load, clear).

Verification
REQ-034 Reset, RESET_PC=0x100, ready=1, 1-cycle response -> addresses 0x100, 0x104, 0x108 issued; inst_pc matches in order.
REQ-035 inst_ready=0 for 5 cycles after first instruction -> inst_valid held, data stable, no second request until handshake.
REQ-036 Redirect to 0x200 while in WAIT -> stale response dropped, next inst_pc=0x200, nothing from old stream delivered.
REQ-037 imem_req_ready low 3 cycles plus redirect to 0x300 meanwhile -> imem_addr stable until accepted, response discarded, next request 0x300.
REQ-038 pc=0xFFFFFFFC fetch -> next address 0x00000000.
REQ-039 rst low during WAIT, then response pulse -> ignored; BOOT one cycle, then request at RESET_PC.
